// File: rtl/bank_pkg.sv
// Shared definitions for the bank_sc storage controller.
//   - LINES / DW      : default geometry (cachelines, data bits per offset)
//   - OP_*            : request opcode encodings (other values are reserved)
//   - state_e         : response FSM state encoding
//   - tag_t           : request tags captured at accept and echoed on every beat
package bank_pkg;

    localparam int LINES = 64;
    localparam int DW    = 128;

    localparam logic [2:0] OP_READ     = 3'b000;
    localparam logic [2:0] OP_LINEFILL = 3'b001;
    localparam logic [2:0] OP_EVICT    = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_LAST  = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0] channel;
        logic [2:0] opcode;
        logic [7:0] wbuffer_id;
        logic [2:0] rob_num;
    } tag_t;

endpackage

// File: rtl/bank_sc_array.sv
// Line storage for bank_sc: per line a valid bit, per offset DW data bits and
// a 2-bit dirty field (plus one even-parity bit when BANK_SC_PARITY_EN is
// defined).
// Ports:
//   clk, rst_n          clock, async active-low reset (valid/dirty only; data
//                       and parity are not reset)
//   wr_en/wr_fill       write port: wr_fill=1 writes both offsets' data and
//                       dirty and sets valid; wr_fill=0 clears valid and
//                       writes wr_dirty (evict clear)
//   wr_line, wr_data, wr_dirty, wr_par (parity builds only)
//   rd_line, rd_off     combinational read port
//   rd_valid, rd_data, rd_dirty, rd_par_err
module bank_sc_array
    import bank_pkg::*;
#(
    parameter int  LINES = bank_pkg::LINES,
    parameter int  DW    = bank_pkg::DW,
    localparam int LW    = $clog2(LINES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic                wr_fill,
    input  logic [LW-1:0]       wr_line,
    input  logic [1:0][DW-1:0]  wr_data,
    input  logic [1:0][1:0]     wr_dirty,
`ifdef BANK_SC_PARITY_EN
    input  logic [1:0]          wr_par,
`endif
    input  logic [LW-1:0]       rd_line,
    input  logic                rd_off,
    output logic                rd_valid,
    output logic [DW-1:0]       rd_data,
    output logic [1:0]          rd_dirty,
    output logic                rd_par_err
);

    logic [DW-1:0]              data_mem [LINES][2];
    logic [LINES-1:0]           valid_q;
    logic [LINES-1:0][1:0][1:0] dirty_q;

    always_ff @(posedge clk) begin
        if (wr_en && wr_fill) begin
            data_mem[wr_line][0] <= wr_data[0];
            data_mem[wr_line][1] <= wr_data[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_line] <= wr_fill;
            dirty_q[wr_line] <= wr_dirty;
        end
    end

    assign rd_valid = valid_q[rd_line];
    assign rd_data  = data_mem[rd_line][rd_off];
    assign rd_dirty = dirty_q[rd_line][rd_off];

`ifdef BANK_SC_PARITY_EN
    logic par_mem [LINES][2];

    always_ff @(posedge clk) begin
        if (wr_en && wr_fill) begin
            par_mem[wr_line][0] <= wr_par[0];
            par_mem[wr_line][1] <= wr_par[1];
        end
    end

    // Even parity: data bits plus stored bit must XOR to zero.
    assign rd_par_err = (^rd_data) ^ par_mem[rd_line][rd_off];
`else
    assign rd_par_err = 1'b0;
`endif

endmodule

// File: rtl/bank_sc.sv
// bank_sc: single-bank cacheline storage controller.
// Accepts READ / LINEFILL / EVICT requests on the isu_sc_* channel and returns
// response beats on sc_rsp_*. LINEFILL completes in IDLE with no response;
// READ returns one beat (latency 1); EVICT returns offset0 then offset1 and
// invalidates the line when the last beat handshakes. Reserved opcodes and
// invalid lines return data=0 with err=1.
// Optional build macro: BANK_SC_PARITY_EN adds per-offset even parity and the
// sc_par_inject_i input (inverts parity written by LINEFILL).
// Ports:
//   clk_i, rst_n_i              clock, async active-low reset
//   isu_sc_valid_i/ready_o      request handshake (ready only in IDLE)
//   isu_sc_*                    request opcode, address, tags, linefill payload
//   sc_rsp_valid_o/ready_i      response beat handshake
//   sc_rsp_*                    echoed tags, data, dirty, last, err
module bank_sc
    import bank_pkg::*;
#(
    parameter int  LINES = bank_pkg::LINES,
    parameter int  DW    = bank_pkg::DW,
    localparam int LW    = $clog2(LINES),
    localparam int SW    = LW + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          isu_sc_valid_i,
    output logic          isu_sc_ready_o,
    input  logic [1:0]    isu_sc_channel_id_i,
    input  logic [2:0]    isu_sc_opcode_i,
    input  logic [SW-1:0] isu_sc_set_way_offset_i,
    input  logic [7:0]    isu_sc_wbuffer_id_i,
    input  logic [2:0]    isu_sc_xbar_rob_num_i,
    input  logic [1:0]    isu_sc_cacheline_dirty_offset0_i,
    input  logic [1:0]    isu_sc_cacheline_dirty_offset1_i,
    input  logic [DW-1:0] isu_sc_linefill_data_offset0_i,
    input  logic [DW-1:0] isu_sc_linefill_data_offset1_i,
`ifdef BANK_SC_PARITY_EN
    input  logic          sc_par_inject_i,
`endif
    output logic          sc_rsp_valid_o,
    input  logic          sc_rsp_ready_i,
    output logic [1:0]    sc_rsp_channel_id_o,
    output logic [2:0]    sc_rsp_opcode_o,
    output logic [7:0]    sc_rsp_wbuffer_id_o,
    output logic [2:0]    sc_rsp_xbar_rob_num_o,
    output logic [DW-1:0] sc_rsp_data_o,
    output logic [1:0]    sc_rsp_dirty_o,
    output logic          sc_rsp_last_o,
    output logic          sc_rsp_err_o
);

    state_e          state, state_nxt;
    logic [LW-1:0]   line_q;
    tag_t            tag_q;
    logic            rsp_valid, rsp_last, rsp_err;
    logic [DW-1:0]   rsp_data;
    logic [1:0]      rsp_dirty;

    logic            accept, hs;
    logic            load, reserved, fill, clear, done;
    logic [LW-1:0]   req_line, rd_line;
    logic            rd_off;
    logic            rd_valid, rd_par_err;
    logic [DW-1:0]   rd_data;
    logic [1:0]      rd_dirty;

    assign isu_sc_ready_o = (state == ST_IDLE);
    assign accept         = isu_sc_valid_i & isu_sc_ready_o;
    assign hs             = rsp_valid & sc_rsp_ready_i;
    assign req_line       = isu_sc_set_way_offset_i[SW-1:1];

    // In IDLE the read port looks at the incoming request (EVICT always starts
    // at offset0); in BEAT0 it fetches offset1 of the captured line.
    assign rd_line = (state == ST_IDLE) ? req_line : line_q;
    assign rd_off  = (state == ST_IDLE) ? ((isu_sc_opcode_i != OP_EVICT) & isu_sc_set_way_offset_i[0])
                                        : 1'b1;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        reserved  = 1'b0;
        fill      = 1'b0;
        clear     = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (isu_sc_opcode_i)
                        OP_READ:     begin load = 1'b1; state_nxt = ST_LAST;  end
                        OP_LINEFILL: begin fill = 1'b1;                       end
                        OP_EVICT:    begin load = 1'b1; state_nxt = ST_BEAT0; end
                        default:     begin load = 1'b1; reserved = 1'b1; state_nxt = ST_LAST; end
                    endcase
                end
            end
            ST_BEAT0: begin
                if (hs) begin
                    load      = 1'b1;
                    state_nxt = ST_LAST;
                end
            end
            ST_LAST: begin
                if (hs) begin
                    done      = 1'b1;
                    clear     = (tag_q.opcode == OP_EVICT);
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tag_q     <= '0;
            line_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_dirty <= '0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept && !fill) begin
                tag_q  <= '{channel:    isu_sc_channel_id_i,
                            opcode:     isu_sc_opcode_i,
                            wbuffer_id: isu_sc_wbuffer_id_i,
                            rob_num:    isu_sc_xbar_rob_num_i};
                line_q <= req_line;
            end
            if (load) begin
                rsp_valid <= 1'b1;
                rsp_last  <= (state_nxt == ST_LAST);
                if (reserved || !rd_valid) begin
                    rsp_data  <= '0;
                    rsp_dirty <= '0;
                    rsp_err   <= 1'b1;
                end else begin
                    rsp_data  <= rd_data;
                    rsp_dirty <= rd_dirty;
                    rsp_err   <= rd_par_err;
                end
            end else if (done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef BANK_SC_PARITY_EN
    logic [1:0] wr_par;
    assign wr_par = {(^isu_sc_linefill_data_offset1_i) ^ sc_par_inject_i,
                     (^isu_sc_linefill_data_offset0_i) ^ sc_par_inject_i};
`endif

    bank_sc_array #(.LINES(LINES), .DW(DW)) u_array (
        .clk        (clk_i),
        .rst_n      (rst_n_i),
        .wr_en      (fill | clear),
        .wr_fill    (fill),
        .wr_line    (fill ? req_line : line_q),
        .wr_data    ({isu_sc_linefill_data_offset1_i, isu_sc_linefill_data_offset0_i}),
        .wr_dirty   (fill ? {isu_sc_cacheline_dirty_offset1_i, isu_sc_cacheline_dirty_offset0_i} : 4'b0),
`ifdef BANK_SC_PARITY_EN
        .wr_par     (wr_par),
`endif
        .rd_line    (rd_line),
        .rd_off     (rd_off),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_dirty   (rd_dirty),
        .rd_par_err (rd_par_err)
    );

    assign sc_rsp_valid_o        = rsp_valid;
    assign sc_rsp_channel_id_o   = tag_q.channel;
    assign sc_rsp_opcode_o       = tag_q.opcode;
    assign sc_rsp_wbuffer_id_o   = tag_q.wbuffer_id;
    assign sc_rsp_xbar_rob_num_o = tag_q.rob_num;
    assign sc_rsp_data_o         = rsp_data;
    assign sc_rsp_dirty_o        = rsp_dirty;
    assign sc_rsp_last_o         = rsp_last;
    assign sc_rsp_err_o          = rsp_err;

endmodule
